mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arb_pkg.sv | 24 ++
 rtl/mem_arb_port_buf.sv | 60 ++++++
 rtl/mem_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arb_pkg                                                          |
// | Shared FSM state type, port indices and width defaults.              |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 16;

  localparam int PORT_FETCH = 0;
  localparam int PORT_DATA  = 1;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_ISSUE  = 3'd1,
    ST_SETTLE = 3'd2,
    ST_WAIT   = 3'd3,
    ST_RESP   = 3'd4
  } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_arb_port_buf.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arb_port_buf                                                     |
// | One-deep request buffer with pending flag and overrun error pulse.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mem_arb_port_buf
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              clr,
  output logic              pending,
  output logic              buf_we,
  output logic [ADDR_W-1:0] buf_addr,
  output logic [DATA_W-1:0] buf_wdata,
  output logic              err
);

  logic w_accept;
  logic w_overrun;
  logic r_pending;
  logic r_err;

  // A request arriving in the completion cycle is taken: set beats clear.
  assign w_accept  = req && (!r_pending || clr);
  assign w_overrun = req && r_pending && !clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= 1'b0;
      r_err     <= 1'b0;
      buf_we    <= 1'b0;
      buf_addr  <= '0;
      buf_wdata <= '0;
    end else begin
      r_err <= w_overrun;
      if (w_accept) begin
        r_pending <= 1'b1;
        buf_we    <= we;
        buf_addr  <= addr;
        buf_wdata <= wdata;
      end else if (clr) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign pending = r_pending;
  assign err     = r_err;

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mem_arbiter                                                          |
// | Two-port round-robin arbiter onto a single start/ready memory.      |
// | Optional WAIT timeout when MEM_ARB_TIMEOUT_EN is defined.            |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_busy,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_busy,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_start,
  output logic              memory_w,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              memory_ready,
  output logic              err
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_gnt;
  logic              r_last_gnt;
  logic              w_sel;
  logic              w_do_sel;
  logic              w_done;
  logic              w_tout;
  logic              w_tout_err;
  logic [1:0]        w_pend;
  logic [1:0]        w_clr;
  logic [1:0]        w_bwe;
  logic [1:0]        w_berr;
  logic [ADDR_W-1:0] w_baddr  [2];
  logic [DATA_W-1:0] w_bwdata [2];
  logic [DATA_W-1:0] r_rdata  [2];

  mem_arb_port_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_buf_fetch (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (p0_req),
    .we        (p0_we),
    .addr      (p0_addr),
    .wdata     (p0_wdata),
    .clr       (w_clr[PORT_FETCH]),
    .pending   (w_pend[PORT_FETCH]),
    .buf_we    (w_bwe[PORT_FETCH]),
    .buf_addr  (w_baddr[PORT_FETCH]),
    .buf_wdata (w_bwdata[PORT_FETCH]),
    .err       (w_berr[PORT_FETCH])
  );

  mem_arb_port_buf #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_buf_data (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (p1_req),
    .we        (p1_we),
    .addr      (p1_addr),
    .wdata     (p1_wdata),
    .clr       (w_clr[PORT_DATA]),
    .pending   (w_pend[PORT_DATA]),
    .buf_we    (w_bwe[PORT_DATA]),
    .buf_addr  (w_baddr[PORT_DATA]),
    .buf_wdata (w_bwdata[PORT_DATA]),
    .err       (w_berr[PORT_DATA])
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_do_sel    = 1'b0;
    w_sel       = 1'b0;
    w_done      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (|w_pend) begin
          w_do_sel    = 1'b1;
          // Contention goes to the port that did not win last time.
          w_sel       = (&w_pend) ? ~r_last_gnt : w_pend[PORT_DATA];
          w_state_nxt = ST_ISSUE;
        end
      end
      ST_ISSUE:  w_state_nxt = ST_SETTLE;
      ST_SETTLE: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (memory_ready || w_tout) begin
          w_done      = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_gnt      <= 1'b0;
      r_last_gnt <= 1'b1;
      mem_addr   <= '0;
      memory_w   <= 1'b0;
      mem_wdata  <= '0;
      r_rdata[0] <= '0;
      r_rdata[1] <= '0;
    end else begin
      if (w_do_sel) begin
        r_gnt      <= w_sel;
        r_last_gnt <= w_sel;
        mem_addr   <= w_baddr[w_sel];
        memory_w   <= w_bwe[w_sel];
        mem_wdata  <= w_bwdata[w_sel];
      end
      if (w_done) r_rdata[r_gnt] <= w_tout ? '0 : mem_rdata;
    end
  end

`ifdef MEM_ARB_TIMEOUT_EN
  localparam int C_TCNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [C_TCNT_W-1:0] r_tcnt;
  logic                r_tout_hit;

  assign w_tout = (r_state == ST_WAIT) && !memory_ready &&
                  (r_tcnt == C_TCNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tcnt     <= '0;
      r_tout_hit <= 1'b0;
    end else begin
      if (r_state == ST_WAIT && !w_done) r_tcnt <= r_tcnt + 1'b1;
      else                               r_tcnt <= '0;
      if (w_done) r_tout_hit <= w_tout;
    end
  end

  assign w_tout_err = (r_state == ST_RESP) && r_tout_hit;
`else
  assign w_tout     = 1'b0;
  assign w_tout_err = 1'b0;

  // TIMEOUT has no effect in this build.
  if (TIMEOUT < 0) begin : g_timeout_unused
  end
`endif

  assign w_clr[PORT_FETCH] = (r_state == ST_RESP) && (r_gnt == 1'b0);
  assign w_clr[PORT_DATA]  = (r_state == ST_RESP) && (r_gnt == 1'b1);

  assign mem_start = (r_state == ST_ISSUE);
  assign p0_busy   = w_pend[PORT_FETCH];
  assign p1_busy   = w_pend[PORT_DATA];
  assign p0_ack    = w_clr[PORT_FETCH];
  assign p1_ack    = w_clr[PORT_DATA];
  assign p0_rdata  = r_rdata[PORT_FETCH];
  assign p1_rdata  = r_rdata[PORT_DATA];
  assign err       = (|w_berr) | w_tout_err;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_mem_arbiter                                                       |
// | Randomized scoreboard bench for mem_arbiter (default build).         |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_mem_arbiter;

  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          p0_req = 1'b0, p0_we = 1'b0;
  logic [AW-1:0] p0_addr = '0;
  logic [DW-1:0] p0_wdata = '0;
  logic          p1_req = 1'b0, p1_we = 1'b0;
  logic [AW-1:0] p1_addr = '0;
  logic [DW-1:0] p1_wdata = '0;
  logic          p0_busy, p0_ack, p1_busy, p1_ack;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic          mem_start, memory_w, err;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;
  logic          memory_ready = 1'b1;
  logic          hold_ready0 = 1'b0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_busy(p0_busy), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_busy(p1_busy), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .mem_start(mem_start), .memory_w(memory_w), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .memory_ready(memory_ready),
    .err(err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  typedef struct {int cyc; logic [AW-1:0] addr; logic we; logic [DW-1:0] wdata;} start_t;
  typedef struct {int cyc; int port; logic [DW-1:0] rdata;} ack_t;

  start_t        sq[$];
  ack_t          aq[$];
  int            eq[$];
  logic [1:0]    m_pend = '0;
  logic [1:0]    m_clr, m_rq;
  logic          m_nerr;
  logic          m_last = 1'b1, m_active = 1'b0, m_in_resp = 1'b0, m_gnt = 1'b0;
  int            m_age = 0;
  logic          m_bwe   [2];
  logic [AW-1:0] m_baddr [2];
  logic [DW-1:0] m_bwd   [2];
  logic [DW-1:0] m_rdata [2];
  start_t        m_cur;

  // Latency rule: select in the IDLE cycle, strobe next cycle, ready ignored
  // for the settle cycle, then first ready cycle completes; ack the cycle after.
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      m_pend = '0; m_last = 1'b1; m_active = 1'b0; m_in_resp = 1'b0; m_age = 0;
      m_rdata[0] = '0; m_rdata[1] = '0;
      sq.delete(); aq.delete(); eq.delete();
    end else begin
      cyc++;
      m_clr = '0;
      if (m_active) begin
        m_age++;
        if (m_in_resp) begin
          m_clr[m_gnt] = 1'b1; m_active = 1'b0; m_in_resp = 1'b0;
        end else if (m_age >= 3 && memory_ready) begin
          m_in_resp = 1'b1;
          m_rdata[m_gnt] = mem_rdata;
          aq.push_back('{cyc, int'(m_gnt), mem_rdata});
        end
      end else if (m_pend != 2'b00) begin
        m_gnt = (m_pend == 2'b11) ? ~m_last : m_pend[1];
        m_last = m_gnt; m_active = 1'b1; m_age = 0;
        m_cur = '{cyc, m_baddr[m_gnt], m_bwe[m_gnt], m_bwd[m_gnt]};
        sq.push_back(m_cur);
      end
      m_rq = {p1_req, p0_req};
      m_nerr = 1'b0;
      for (int k = 0; k < 2; k++) begin
        if (m_rq[k]) begin
          if (!m_pend[k] || m_clr[k]) begin
            m_pend[k]  = 1'b1;
            m_bwe[k]   = (k == 0) ? p0_we : p1_we;
            m_baddr[k] = (k == 0) ? p0_addr : p1_addr;
            m_bwd[k]   = (k == 0) ? p0_wdata : p1_wdata;
          end else begin
            m_nerr = 1'b1;
          end
        end else if (m_clr[k]) begin
          m_pend[k] = 1'b0;
        end
      end
      if (m_nerr) eq.push_back(cyc);
    end
  end

  // ---------------- monitor ----------------
  start_t st_e;
  ack_t   ak_e;
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (sq.size() > 0 && sq[0].cyc == cyc) begin
        st_e = sq.pop_front();
        chk("mem_start", mem_start, 1);
        chk("issue_addr", mem_addr, st_e.addr);
        chk("issue_we", memory_w, st_e.we);
        chk("issue_wdata", mem_wdata, st_e.wdata);
      end else begin
        chk("mem_start_idle", mem_start, 0);
      end
      if (aq.size() > 0 && aq[0].cyc == cyc) begin
        ak_e = aq.pop_front();
        chk("ack_port", {p1_ack, p0_ack}, (ak_e.port == 1) ? 2'b10 : 2'b01);
        chk("ack_rdata", (ak_e.port == 1) ? p1_rdata : p0_rdata, ak_e.rdata);
      end else begin
        chk("ack_idle", {p1_ack, p0_ack}, 2'b00);
      end
      if (eq.size() > 0 && eq[0] == cyc) begin
        void'(eq.pop_front());
        chk("err_pulse", err, 1);
      end else begin
        chk("err_idle", err, 0);
      end
      chk("p0_busy", p0_busy, m_pend[0]);
      chk("p1_busy", p1_busy, m_pend[1]);
      chk("p0_rdata_hold", p0_rdata, m_rdata[0]);
      chk("p1_rdata_hold", p1_rdata, m_rdata[1]);
      if (m_active) begin
        chk("stable_addr", mem_addr, m_cur.addr);
        chk("stable_we", memory_w, m_cur.we);
        chk("stable_wdata", mem_wdata, m_cur.wdata);
      end
    end
  end

  // ---------------- memory responder ----------------
  initial forever begin
    @(negedge clk);
    memory_ready = hold_ready0 ? 1'b0 : ($urandom_range(0, 2) != 0);
    mem_rdata    = DW'($urandom);
  end

  // ---------------- stimulus ----------------
  task automatic check_reset_outputs(input string tag);
    chk({tag, "_p0_busy"}, p0_busy, 0);
    chk({tag, "_p1_busy"}, p1_busy, 0);
    chk({tag, "_p0_ack"}, p0_ack, 0);
    chk({tag, "_p1_ack"}, p1_ack, 0);
    chk({tag, "_mem_start"}, mem_start, 0);
    chk({tag, "_memory_w"}, memory_w, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_wdata"}, mem_wdata, 0);
    chk({tag, "_p0_rdata"}, p0_rdata, 0);
    chk({tag, "_p1_rdata"}, p1_rdata, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_p(input int k, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (k == 0) begin p0_we = we; p0_addr = a; p0_wdata = d; end
    else        begin p1_we = we; p1_addr = a; p1_wdata = d; end
  endtask

  task automatic pulse(input logic r0, input logic r1);
    @(negedge clk);
    p0_req = r0; p1_req = r1;
    @(negedge clk);
    p0_req = 1'b0; p1_req = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((m_active || m_pend != 2'b00) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({"drain_", nm}, (n < 300), 1);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #3 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    set_p(0, 1'b0, 16'h0010, 16'h0000);
    pulse(1'b1, 1'b0);
    wait_idle("single_read");

    do_reset();
    set_p(0, 1'b0, 16'h0100, 16'h0000);
    set_p(1, 1'b0, 16'h0200, 16'h0000);
    pulse(1'b1, 1'b1);
    wait_idle("rr_first");
    set_p(0, 1'b0, 16'h0110, 16'h0000);
    set_p(1, 1'b0, 16'h0210, 16'h0000);
    pulse(1'b1, 1'b1);
    wait_idle("rr_second");

    set_p(1, 1'b0, 16'h0300, 16'h0000);
    pulse(1'b0, 1'b1);
    set_p(1, 1'b0, 16'h03FF, 16'h0000);
    pulse(1'b0, 1'b1);
    wait_idle("overrun");

    set_p(1, 1'b1, 16'hFFFF, 16'hA5A5);
    pulse(1'b0, 1'b1);
    wait_idle("write");

    hold_ready0 = 1'b1;
    set_p(0, 1'b0, 16'h1234, 16'h0000);
    pulse(1'b1, 1'b0);
    begin
      int n = 0;
      while (!(m_active && m_age >= 2) && n < 50) begin
        @(negedge clk);
        n++;
      end
      chk("reach_wait", (n < 50), 1);
    end
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    hold_ready0 = 1'b0;
    set_p(0, 1'b0, 16'h4321, 16'h0000);
    pulse(1'b1, 1'b0);
    wait_idle("after_reset");

    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      p0_req   = ($urandom_range(0, 3) == 0);
      p1_req   = ($urandom_range(0, 3) == 0);
      p0_we    = 1'($urandom_range(0, 1));
      p1_we    = 1'($urandom_range(0, 1));
      p0_addr  = AW'($urandom);
      p1_addr  = AW'($urandom);
      p0_wdata = DW'($urandom);
      p1_wdata = DW'($urandom);
    end
    @(negedge clk);
    p0_req = 1'b0; p1_req = 1'b0;
    wait_idle("random");

    chk("scoreboard_drained", sq.size() + aq.size() + eq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
